// File: rtl/lp_expect_tracker.sv
// Commit-side landing-pad expectation (ELP) tracker; state/outputs update one cycle after the qualifying commit.
// No backpressure: every committed instruction is observed, and a raised fault is held until a trap acknowledges it.
module lp_expect_tracker #(
    parameter int LBL_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             xlpad_i,
    input  logic             debug_mode_i,
    input  logic             commit_valid_i,
    input  logic             commit_is_indirect_i,
    input  logic             commit_is_lpad_i,
    input  logic [LBL_W-1:0] commit_label_i,
    input  logic [1:0]       complete_cfi_i,
    input  logic             trap_i,
    input  logic             xret_i,
    input  logic             pelp_i,
    output logic             elp_o,
    output logic             pelp_o,
    output logic [LBL_W-1:0] expected_label_o,
    output logic             lp_fault_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    // Encoding chosen so bit0 is ELP and bit1 is the fault request straight off the flops.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPECT = 2'b01,
        FAULT  = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   arm;
    logic   fault_entry;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (trap_i) begin
            state_nxt = IDLE;
        end else if (state == FAULT) begin
            state_nxt = FAULT;
        end else if (xret_i) begin
            state_nxt = (pelp_i && xlpad_i && !debug_mode_i) ? EXPECT : IDLE;
        end else if (!xlpad_i || debug_mode_i) begin
            state_nxt = IDLE;
        end else if (commit_valid_i) begin
            case (state)
                IDLE:    if (commit_is_indirect_i) state_nxt = EXPECT;
                // Only a checked-and-matching LPAD clears the expectation.
                EXPECT:  state_nxt = (commit_is_lpad_i && complete_cfi_i == 2'b11) ? IDLE : FAULT;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        elp_o      = state[0];
        lp_fault_o = state[1];
        pelp_o     = state[0];
    end

    // The label is captured only when a commit arms the tracker, not on xRET restore.
    assign arm         = (state == IDLE) && (state_nxt == EXPECT) && !xret_i;
    assign fault_entry = (state != FAULT) && (state_nxt == FAULT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            expected_label_o <= '0;
        end else if (arm) begin
            expected_label_o <= commit_label_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_o <= '0;
        end else if (fault_entry && (fault_cnt_o != {CNT_W{1'b1}})) begin
            fault_cnt_o <= fault_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lp_expect_tracker.sv
// Bench for lp_expect_tracker: directed commits/traps/xRETs with a scoreboard of expected outputs.
// A second instance with a 3-bit counter shares all inputs and exercises counter saturation.
module tb_lp_expect_tracker;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        xlpad_i = 1'b1;
    logic        debug_mode_i = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic        commit_is_indirect_i = 1'b0;
    logic        commit_is_lpad_i = 1'b0;
    logic [19:0] commit_label_i = '0;
    logic [1:0]  complete_cfi_i = 2'b01;
    logic        trap_i = 1'b0;
    logic        xret_i = 1'b0;
    logic        pelp_i = 1'b0;

    logic        elp_o, pelp_o, lp_fault_o;
    logic [19:0] expected_label_o;
    logic [15:0] fault_cnt_o;
    logic        elp_s, pelp_s, lp_fault_s;
    logic [19:0] label_s;
    logic [2:0]  cnt_s;

    always #5 clk_i = ~clk_i;

    lp_expect_tracker u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .xlpad_i(xlpad_i), .debug_mode_i(debug_mode_i),
        .commit_valid_i(commit_valid_i), .commit_is_indirect_i(commit_is_indirect_i),
        .commit_is_lpad_i(commit_is_lpad_i), .commit_label_i(commit_label_i),
        .complete_cfi_i(complete_cfi_i), .trap_i(trap_i), .xret_i(xret_i), .pelp_i(pelp_i),
        .elp_o(elp_o), .pelp_o(pelp_o), .expected_label_o(expected_label_o),
        .lp_fault_o(lp_fault_o), .fault_cnt_o(fault_cnt_o)
    );

    lp_expect_tracker #(.LBL_W(20), .CNT_W(3)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .xlpad_i(xlpad_i), .debug_mode_i(debug_mode_i),
        .commit_valid_i(commit_valid_i), .commit_is_indirect_i(commit_is_indirect_i),
        .commit_is_lpad_i(commit_is_lpad_i), .commit_label_i(commit_label_i),
        .complete_cfi_i(complete_cfi_i), .trap_i(trap_i), .xret_i(xret_i), .pelp_i(pelp_i),
        .elp_o(elp_s), .pelp_o(pelp_s), .expected_label_o(label_s),
        .lp_fault_o(lp_fault_s), .fault_cnt_o(cnt_s)
    );

    typedef struct {
        string       nm;
        logic        elp;
        logic        pelp;
        logic        fault;
        logic [19:0] label;
        logic [15:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    event sample_now;
    int   errors = 0;
    int   checks = 0;
    int   fc = 0;

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the oldest expectation at every sample point.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or sample_now);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.nm, "elp",   32'(elp_o),            32'(e.elp));
                check(e.nm, "pelp",  32'(pelp_o),           32'(e.pelp));
                check(e.nm, "fault", 32'(lp_fault_o),       32'(e.fault));
                check(e.nm, "label", 32'(expected_label_o), 32'(e.label));
                check(e.nm, "cnt",   32'(fault_cnt_o),      32'(e.cnt));
                check(e.nm, "cnt_s", 32'(cnt_s),            32'(e.cnt_s));
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic elp, input logic fault,
                                input logic [19:0] label, input int cnt);
        exp_t e;
        e.nm    = nm;
        e.elp   = elp;
        e.pelp  = elp;
        e.fault = fault;
        e.label = label;
        e.cnt   = 16'(cnt);
        e.cnt_s = (cnt > 7) ? 3'd7 : 3'(cnt);
        return e;
    endfunction

    task automatic expect_now(input exp_t e);
        sb_q.push_back(e);
        -> sample_now;
        #2;
    endtask

    // One clock of stimulus; trap cycles also check pelp_o against the pre-trap state.
    task automatic cyc(input string nm, input logic cv, input logic ind, input logic lpad,
                       input logic [19:0] lbl, input logic [1:0] cfi, input logic trap,
                       input logic xret, input logic pelp, input logic xl, input logic dbg,
                       input logic e_elp, input logic e_fault, input logic [19:0] e_lbl);
        @(negedge clk_i);
        commit_valid_i       = cv;
        commit_is_indirect_i = ind;
        commit_is_lpad_i     = lpad;
        commit_label_i       = lbl;
        complete_cfi_i       = cfi;
        trap_i               = trap;
        xret_i               = xret;
        pelp_i               = pelp;
        xlpad_i              = xl;
        debug_mode_i         = dbg;
        if (trap) begin
            exp_t pre;
            pre    = last;
            pre.nm = {nm, "_pre"};
            expect_now(pre);
        end
        last = mk(nm, e_elp, e_fault, e_lbl, fc);
        sb_q.push_back(last);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk_i);
        expect_now(mk("reset", 1'b0, 1'b0, 20'h0, 0));
        @(negedge clk_i);
        rst_i = 1'b0;
        last  = mk("idle", 1'b0, 1'b0, 20'h0, 0);

        cyc("arm",        1,1,0, 20'h12345, 2'b01, 0,0,0, 1,0,  1,0, 20'h12345);
        cyc("lpad_ok",    1,0,1, 20'h0,     2'b11, 0,0,0, 1,0,  0,0, 20'h12345);
        cyc("idle_hold",  0,0,0, 20'h0,     2'b01, 0,0,0, 1,0,  0,0, 20'h12345);
        cyc("arm2",       1,1,0, 20'hABCDE, 2'b01, 0,0,0, 1,0,  1,0, 20'hABCDE);
        fc = 1;
        cyc("add_fault",  1,0,0, 20'h0,     2'b10, 0,0,0, 1,0,  1,1, 20'hABCDE);
        cyc("flt_lpad",   1,0,1, 20'h0,     2'b11, 0,0,0, 1,0,  1,1, 20'hABCDE);
        cyc("flt_jalr",   1,1,0, 20'h11111, 2'b01, 0,0,0, 1,0,  1,1, 20'hABCDE);
        cyc("trap",       0,0,0, 20'h0,     2'b01, 1,0,0, 1,0,  0,0, 20'hABCDE);
        cyc("arm3",       1,1,0, 20'h00F0F, 2'b01, 0,0,0, 1,0,  1,0, 20'h00F0F);
        fc = 2;
        cyc("cfi_mis",    1,0,1, 20'h0,     2'b00, 0,0,0, 1,0,  1,1, 20'h00F0F);
        cyc("trap2",      0,0,0, 20'h0,     2'b01, 1,0,0, 1,0,  0,0, 20'h00F0F);
        cyc("arm4",       1,1,0, 20'h22222, 2'b01, 0,0,0, 1,0,  1,0, 20'h22222);
        fc = 3;
        cyc("cfi_nochk",  1,0,1, 20'h0,     2'b10, 0,0,0, 1,0,  1,1, 20'h22222);

        // Asynchronous reset in FAULT with three faults counted.
        @(negedge clk_i);
        commit_valid_i = 1'b0; commit_is_lpad_i = 1'b0; complete_cfi_i = 2'b01;
        expect_now(mk("pre_rst", 1'b1, 1'b1, 20'h22222, 3));
        rst_i = 1'b1;
        fc = 0;
        expect_now(mk("async_rst", 1'b0, 1'b0, 20'h0, 0));
        @(negedge clk_i);
        rst_i = 1'b0;
        last  = mk("post_rst", 1'b0, 1'b0, 20'h0, 0);
        cyc("post_rst",   0,0,0, 20'h0,     2'b01, 0,0,0, 1,0,  0,0, 20'h0);

        cyc("arm5",       1,1,0, 20'h33333, 2'b01, 0,0,0, 1,0,  1,0, 20'h33333);
        fc = 1;
        cyc("cfi_idle",   1,0,1, 20'h0,     2'b01, 0,0,0, 1,0,  1,1, 20'h33333);
        cyc("trap3",      0,0,0, 20'h0,     2'b01, 1,0,0, 1,0,  0,0, 20'h33333);
        cyc("trap_jalr",  1,1,0, 20'h44444, 2'b01, 1,0,0, 1,0,  0,0, 20'h33333);
        cyc("xret_rest",  0,0,0, 20'h0,     2'b01, 0,1,1, 1,0,  1,0, 20'h33333);
        cyc("xret_commit",1,0,1, 20'h0,     2'b00, 0,1,0, 1,0,  0,0, 20'h33333);
        cyc("dbg_jalr",   1,1,0, 20'h55555, 2'b01, 0,0,0, 1,1,  0,0, 20'h33333);
        cyc("arm6",       1,1,0, 20'h66666, 2'b01, 0,0,0, 1,0,  1,0, 20'h66666);
        cyc("xlpad_off",  0,0,0, 20'h0,     2'b01, 0,0,0, 0,0,  0,0, 20'h66666);
        cyc("xl_off_jalr",1,1,0, 20'h77777, 2'b01, 0,0,0, 0,0,  0,0, 20'h66666);
        cyc("arm7",       1,1,0, 20'h88888, 2'b01, 0,0,0, 1,0,  1,0, 20'h88888);
        cyc("dbg_clear",  0,0,0, 20'h0,     2'b01, 0,0,0, 1,1,  0,0, 20'h88888);
        cyc("arm8",       1,1,0, 20'h99999, 2'b01, 0,0,0, 1,0,  1,0, 20'h99999);
        fc = 2;
        cyc("jalr_in_exp",1,1,0, 20'hAAAAA, 2'b01, 0,0,0, 1,0,  1,1, 20'h99999);
        cyc("flt_xl_off", 0,0,0, 20'h0,     2'b01, 0,0,0, 0,0,  1,1, 20'h99999);
        cyc("flt_xret",   0,0,0, 20'h0,     2'b01, 0,1,0, 1,0,  1,1, 20'h99999);
        cyc("trap4",      0,0,0, 20'h0,     2'b01, 1,1,1, 1,0,  0,0, 20'h99999);
        cyc("xret_no_xl", 0,0,0, 20'h0,     2'b01, 0,1,1, 0,0,  0,0, 20'h99999);

        // Drive the counter past the 3-bit instance's ceiling of 7.
        for (int i = 1; i <= 6; i++) begin
            logic [19:0] lbl;
            lbl = 20'(i * 20'h01010);
            cyc("sat_arm",   1,1,0, lbl,  2'b01, 0,0,0, 1,0,  1,0, lbl);
            fc++;
            cyc("sat_fault", 1,0,0, 20'h0, 2'b01, 0,0,0, 1,0,  1,1, lbl);
            cyc("sat_trap",  0,0,0, 20'h0, 2'b01, 1,0,0, 1,0,  0,0, lbl);
        end

        repeat (3) @(negedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0 pending", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
